// File: rtl/dmem_arbiter.sv
// Round-robin arbiter that lets two requesters share a single-port data memory.
// Each access takes three cycles: IDLE (arbitrate and latch), ACCESS (memory strobe), RESP (completion).
module dmem_arbiter #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 14
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             a_req,
  input  logic             a_we,
  input  logic [WIDTH-1:0] a_addr,
  input  logic [WIDTH-1:0] a_wdata,
  output logic             a_gnt,
  output logic             a_rvalid,
  output logic [WIDTH-1:0] a_rdata,
  output logic             a_err,
  input  logic             b_req,
  input  logic             b_we,
  input  logic [WIDTH-1:0] b_addr,
  input  logic [WIDTH-1:0] b_wdata,
  output logic             b_gnt,
  output logic             b_rvalid,
  output logic [WIDTH-1:0] b_rdata,
  output logic             b_err,
  output logic [WIDTH-1:0] mem_addr,
  output logic [WIDTH-1:0] mem_wd,
  output logic             mem_read,
  output logic             mem_write,
  input  logic [WIDTH-1:0] mem_rd
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t           state_reg, state_next;
  logic             last_b_reg;
  logic             sel_b_reg;
  logic             we_reg;
  logic [WIDTH-1:0] addr_reg;
  logic [WIDTH-1:0] wdata_reg;
  logic [WIDTH-1:0] a_rdata_reg;
  logic [WIDTH-1:0] b_rdata_reg;
  logic             win_b;
  logic             in_range;
  logic [WIDTH-1:0] rd_value;

  // B wins when it is alone, or when both ask and A was served last.
  assign win_b    = b_req & (~a_req | ~last_b_reg);
  assign in_range = addr_reg < WIDTH'(DEPTH);
  assign rd_value = (in_range && !we_reg) ? mem_rd : '0;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      last_b_reg <= 1'b1;
      sel_b_reg  <= 1'b0;
      we_reg     <= 1'b0;
      addr_reg   <= '0;
      wdata_reg  <= '0;
    end else if (state_reg == IDLE && (a_req || b_req)) begin
      last_b_reg <= win_b;
      sel_b_reg  <= win_b;
      we_reg     <= win_b ? b_we    : a_we;
      addr_reg   <= win_b ? b_addr  : a_addr;
      wdata_reg  <= win_b ? b_wdata : a_wdata;
    end
  end

  // Read data is captured from the combinational memory port as ACCESS ends.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      a_rdata_reg <= '0;
      b_rdata_reg <= '0;
    end else if (state_reg == ACCESS) begin
      if (sel_b_reg) begin
        b_rdata_reg <= rd_value;
      end else begin
        a_rdata_reg <= rd_value;
      end
    end
  end

  always_comb begin
    state_next = state_reg;
    a_gnt      = 1'b0;
    b_gnt      = 1'b0;
    a_rvalid   = 1'b0;
    b_rvalid   = 1'b0;
    a_err      = 1'b0;
    b_err      = 1'b0;
    mem_addr   = '0;
    mem_wd     = '0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    case (state_reg)
      IDLE: begin
        if (a_req || b_req) begin
          state_next = ACCESS;
        end
      end
      ACCESS: begin
        state_next = RESP;
        a_gnt      = ~sel_b_reg;
        b_gnt      = sel_b_reg;
        if (in_range) begin
          mem_addr  = addr_reg;
          mem_read  = ~we_reg;
          mem_write = we_reg;
          mem_wd    = we_reg ? wdata_reg : '0;
        end
      end
      RESP: begin
        state_next = IDLE;
        a_rvalid   = ~sel_b_reg;
        b_rvalid   = sel_b_reg;
        a_err      = ~sel_b_reg & ~in_range;
        b_err      = sel_b_reg & ~in_range;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign a_rdata = a_rdata_reg;
  assign b_rdata = b_rdata_reg;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: a transaction-level model predicts every output each cycle,
// and directed scenarios add hand-computed literal checks.
module tb_dmem_arbiter;
  localparam int WIDTH = 32;
  localparam int DEPTH = 14;

  logic             clock = 1'b0;
  logic             reset_n = 1'b0;
  logic             a_req, a_we, b_req, b_we;
  logic [WIDTH-1:0] a_addr, a_wdata, b_addr, b_wdata;
  logic             a_gnt, a_rvalid, a_err, b_gnt, b_rvalid, b_err;
  logic [WIDTH-1:0] a_rdata, b_rdata;
  logic [WIDTH-1:0] mem_addr, mem_wd, mem_rd;
  logic             mem_read, mem_write;

  dmem_arbiter #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clock(clock), .reset_n(reset_n),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata), .a_err(a_err),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata), .b_err(b_err),
    .mem_addr(mem_addr), .mem_wd(mem_wd), .mem_read(mem_read),
    .mem_write(mem_write), .mem_rd(mem_rd)
  );

  always #5 clock = ~clock;

  // Simple memory behind the arbiter: combinational read, write on the clock edge.
  logic [WIDTH-1:0] bmem [16];
  assign mem_rd = bmem[mem_addr[3:0]];
  always @(posedge clock) begin
    if (mem_write) bmem[mem_addr[3:0]] <= mem_wd;
  end

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: a transaction accepted at edge m_acc owns the bus during window m_acc
  // (grant + strobe) and window m_acc+1 (completion); next accept no sooner than m_acc+3.
  int               n;
  bit               m_valid, m_b, m_we, m_last_b;
  int               m_acc, m_free;
  logic [WIDTH-1:0] m_addr, m_wdata, m_r, m_a_rdata, m_b_rdata;
  logic [WIDTH-1:0] m_mem [16];

  initial begin
    n = 0; m_valid = 0; m_free = 0; m_last_b = 1; m_acc = 0;
    m_a_rdata = 0; m_b_rdata = 0;
    for (int i = 0; i < 16; i++) begin
      m_mem[i] = 0;
      bmem[i] = 0;
    end
    forever begin
      @(posedge clock);
      n++;
      if (!reset_n) begin
        m_valid = 0; m_free = 0; m_last_b = 1; m_a_rdata = 0; m_b_rdata = 0;
      end else begin
        if (m_valid && n == m_acc + 1) begin
          m_r = 0;
          if (m_addr < DEPTH) begin
            if (m_we) m_mem[m_addr[3:0]] = m_wdata;
            else m_r = m_mem[m_addr[3:0]];
          end
          if (m_b) m_b_rdata = m_r;
          else m_a_rdata = m_r;
        end
        if (n >= m_free && (a_req || b_req)) begin
          m_b      = b_req && (!a_req || !m_last_b);
          m_last_b = m_b;
          m_we     = m_b ? b_we : a_we;
          m_addr   = m_b ? b_addr : a_addr;
          m_wdata  = m_b ? b_wdata : a_wdata;
          m_valid  = 1;
          m_acc    = n;
          m_free   = n + 3;
        end
      end
    end
  end

  logic             e_a_gnt, e_b_gnt, e_a_rv, e_b_rv, e_a_err, e_b_err, e_rd, e_wr, e_in;
  logic [WIDTH-1:0] e_addr, e_wd, e_a_rdata, e_b_rdata;
  int               g_who[$];
  int               g_cyc[$];
  int               rd_strobes = 0;

  initial begin
    forever begin
      @(negedge clock);
      e_a_gnt = 0; e_b_gnt = 0; e_a_rv = 0; e_b_rv = 0; e_a_err = 0; e_b_err = 0;
      e_rd = 0; e_wr = 0; e_addr = 0; e_wd = 0; e_a_rdata = 0; e_b_rdata = 0;
      e_in = m_addr < DEPTH;
      if (reset_n) begin
        e_a_rdata = m_a_rdata;
        e_b_rdata = m_b_rdata;
        if (m_valid && n == m_acc) begin
          e_a_gnt = !m_b; e_b_gnt = m_b;
          if (e_in) begin
            e_rd = !m_we; e_wr = m_we; e_addr = m_addr;
            e_wd = m_we ? m_wdata : 0;
          end
        end
        if (m_valid && n == m_acc + 1) begin
          e_a_rv = !m_b; e_b_rv = m_b;
          e_a_err = !m_b && !e_in; e_b_err = m_b && !e_in;
        end
      end
      chk("a_gnt", a_gnt, e_a_gnt);       chk("b_gnt", b_gnt, e_b_gnt);
      chk("a_rvalid", a_rvalid, e_a_rv);  chk("b_rvalid", b_rvalid, e_b_rv);
      chk("a_err", a_err, e_a_err);       chk("b_err", b_err, e_b_err);
      chk("a_rdata", a_rdata, e_a_rdata); chk("b_rdata", b_rdata, e_b_rdata);
      chk("mem_read", mem_read, e_rd);    chk("mem_write", mem_write, e_wr);
      chk("mem_addr", mem_addr, e_addr);  chk("mem_wd", mem_wd, e_wd);
      if (a_gnt) begin g_who.push_back(0); g_cyc.push_back(n); end
      if (b_gnt) begin g_who.push_back(1); g_cyc.push_back(n); end
      if (mem_read) rd_strobes++;
    end
  end

  task automatic tick(input int k);
    repeat (k) @(posedge clock);
    #1;
  endtask

  task automatic set_a(input bit req, input bit we, input logic [31:0] addr, input logic [31:0] wdata);
    a_req = req; a_we = we; a_addr = addr; a_wdata = wdata;
  endtask

  task automatic set_b(input bit req, input bit we, input logic [31:0] addr, input logic [31:0] wdata);
    b_req = req; b_we = we; b_addr = addr; b_wdata = wdata;
  endtask

  task automatic do_a(input bit we, input logic [31:0] addr, input logic [31:0] wdata);
    set_a(1, we, addr, wdata);
    tick(1);
    set_a(0, 0, 0, 0);
    tick(2);
  endtask

  int c0;
  int lim;

  initial begin
    set_a(0, 0, 0, 0);
    set_b(0, 0, 0, 0);
    reset_n = 0;
    tick(3);
    chk("rst_a_gnt", a_gnt, 0);
    chk("rst_mem_read", mem_read, 0);
    chk("rst_a_rdata", a_rdata, 0);
    chk("rst_b_rdata", b_rdata, 0);
    reset_n = 1;

    // Tie right after reset: A first, then strict alternation every 3 cycles.
    g_who.delete(); g_cyc.delete();
    set_a(1, 0, 1, 0); set_b(1, 0, 2, 0);
    tick(12);
    set_a(0, 0, 0, 0); set_b(0, 0, 0, 0);
    tick(3);
    chk("tie_count", g_who.size(), 4);
    lim = (g_who.size() < 4) ? g_who.size() : 4;
    for (int i = 0; i < lim; i++) begin
      chk("tie_who", g_who[i], i % 2);
      if (i > 0) chk("tie_gap", g_cyc[i] - g_cyc[i-1], 3);
    end

    // Single write then read-back by A.
    set_a(1, 1, 3, 32'hDEADBEEF);
    tick(1);
    chk("wr_mem_write", mem_write, 1);
    chk("wr_mem_addr", mem_addr, 3);
    chk("wr_mem_wd", mem_wd, 32'hDEADBEEF);
    set_a(0, 0, 0, 0);
    tick(1);
    chk("wr_strobe_once", mem_write, 0);
    chk("wr_a_rvalid", a_rvalid, 1);
    tick(1);
    set_a(1, 0, 3, 0);
    tick(1);
    chk("rd_a_gnt", a_gnt, 1);
    chk("rd_mem_read", mem_read, 1);
    set_a(0, 0, 0, 0);
    tick(1);
    chk("rd_a_rvalid", a_rvalid, 1);
    chk("rd_a_rdata", a_rdata, 32'hDEADBEEF);
    chk("rd_a_err", a_err, 0);
    tick(1);

    // B reads valid data, then an out-of-range address clears b_rdata.
    set_b(1, 0, 3, 0);
    tick(1);
    set_b(0, 0, 0, 0);
    tick(2);
    chk("b_rd3", b_rdata, 32'hDEADBEEF);
    set_b(1, 0, 14, 0);
    tick(1);
    chk("rng_b_gnt", b_gnt, 1);
    chk("rng_mem_read", mem_read, 0);
    set_b(0, 0, 0, 0);
    tick(1);
    chk("rng_b_rvalid", b_rvalid, 1);
    chk("rng_b_err", b_err, 1);
    chk("rng_b_rdata", b_rdata, 0);
    tick(1);

    // Address change during ACCESS must not reach the memory.
    do_a(1, 2, 32'h22222222);
    do_a(1, 5, 32'h55555555);
    set_a(1, 0, 2, 0);
    tick(1);
    a_addr = 5;
    #1;
    chk("stab_mem_addr", mem_addr, 2);
    a_req = 0;
    tick(1);
    chk("stab_a_rdata", a_rdata, 32'h22222222);
    tick(1);

    // B asks while A is in RESP: served after the next IDLE, exactly once.
    c0 = rd_strobes;
    set_a(1, 0, 5, 0);
    tick(1);
    set_a(0, 0, 0, 0);
    tick(1);
    chk("blk_a_rvalid", a_rvalid, 1);
    set_b(1, 0, 3, 0);
    tick(1);
    chk("blk_b_gnt_idle", b_gnt, 0);
    chk("blk_mem_read_idle", mem_read, 0);
    tick(1);
    chk("blk_b_gnt", b_gnt, 1);
    chk("blk_mem_addr", mem_addr, 3);
    set_b(0, 0, 0, 0);
    tick(1);
    chk("blk_b_rdata", b_rdata, 32'hDEADBEEF);
    tick(1);
    chk("blk_strobes", rd_strobes - c0, 2);
    chk("blk_a_rdata", a_rdata, 32'h55555555);

    // Reset in the middle of a write: strobe drops at once, write never lands.
    set_a(1, 1, 4, 32'h44444444);
    tick(1);
    chk("rstmid_pre_write", mem_write, 1);
    #2;
    reset_n = 0;
    #1;
    chk("rstmid_mem_write", mem_write, 0);
    chk("rstmid_a_gnt", a_gnt, 0);
    set_a(0, 0, 0, 0);
    tick(2);
    reset_n = 1;
    tick(4);
    chk("rstmid_a_rdata", a_rdata, 0);
    set_a(1, 0, 4, 0);
    tick(1);
    set_a(0, 0, 0, 0);
    tick(1);
    chk("rstmid_no_write", a_rdata, 0);
    chk("rstmid_rvalid", a_rvalid, 1);
    tick(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
